// File: rtl/gigatron_pkg.sv
// Shared widths, types and the default reset vector for the Gigatron program counter.
package gigatron_pkg;

    localparam int unsigned PC_W     = 16;
    localparam int unsigned SLICE_W  = 4;
    localparam int unsigned N_SLICES = PC_W / SLICE_W;

    typedef logic [PC_W-1:0] pc_t;

    localparam pc_t RESET_VECTOR_DEFAULT = 16'h0000;

endpackage

// File: rtl/x74xx163.sv
// 4-bit synchronous counter modelled on the 74xx163: sync clear, sync parallel load,
// dual count enables, and a terminal count gated by CET only.
module x74xx163
    import gigatron_pkg::*;
#(
    parameter logic [SLICE_W-1:0] CLEAR_VALUE = '0
) (
    input  logic MR_N,
    input  logic CP,
    input  logic D0,
    input  logic D1,
    input  logic D2,
    input  logic D3,
    input  logic CEP,
    input  logic PE_N,
    input  logic CET,
    output logic Q0,
    output logic Q1,
    output logic Q2,
    output logic Q3,
    output logic TC
);

    logic [SLICE_W-1:0] r_q;

    always_ff @(posedge CP) begin
        if (!MR_N) begin
            r_q <= CLEAR_VALUE;
        end else if (!PE_N) begin
            r_q <= {D3, D2, D1, D0};
        end else if (CEP && CET) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign {Q3, Q2, Q1, Q0} = r_q;
    // TC looks at the present count, so a slice being loaded still reports carry.
    assign TC = CET & (r_q == '1);

endmodule

// File: rtl/gigatron_pc.sv
// Gigatron 16-bit program counter: four 74xx163 slices cascaded through their TC outputs.
module gigatron_pc
    import gigatron_pkg::*;
#(
    parameter pc_t RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        clock_50,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        load_lo_n,
    input  logic        load_hi_n,
    input  logic [7:0]  d_lo,
    input  logic [7:0]  d_hi,
    output logic [15:0] pc,
    output logic        tc
);

    logic [N_SLICES-1:0] w_tc;
    logic [N_SLICES-1:0] w_cet;
    logic [N_SLICES-1:0] w_pe_n;
    pc_t                 w_d;
    pc_t                 w_q;

    assign w_d    = {d_hi, d_lo};
    assign w_cet  = {w_tc[N_SLICES-2:0], ce};
    assign w_pe_n = {load_hi_n, load_hi_n, load_lo_n, load_lo_n};

    for (genvar k = 0; k < N_SLICES; k++) begin : g_slice
        x74xx163 #(
            .CLEAR_VALUE(RESET_VECTOR[SLICE_W*k +: SLICE_W])
        ) u_slice (
            .MR_N (reset_n),
            .CP   (clock_50),
            .D0   (w_d[SLICE_W*k]),
            .D1   (w_d[SLICE_W*k+1]),
            .D2   (w_d[SLICE_W*k+2]),
            .D3   (w_d[SLICE_W*k+3]),
            .CEP  (ce),
            .PE_N (w_pe_n[k]),
            .CET  (w_cet[k]),
            .Q0   (w_q[SLICE_W*k]),
            .Q1   (w_q[SLICE_W*k+1]),
            .Q2   (w_q[SLICE_W*k+2]),
            .Q3   (w_q[SLICE_W*k+3]),
            .TC   (w_tc[k])
        );
    end

    assign pc = w_q;
    assign tc = w_tc[N_SLICES-1];

endmodule

// File: tb/tb_gigatron_pc.sv
// Self-checking bench for gigatron_pc: byte-level reference model plus directed literal checks.
module tb_gigatron_pc;

    logic        clock_50;
    logic        reset_n;
    logic        ce;
    logic        load_lo_n;
    logic        load_hi_n;
    logic [7:0]  d_lo;
    logic [7:0]  d_hi;
    logic [15:0] pc;
    logic        tc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_pc;
    logic        m_valid = 1'b0;

    gigatron_pc #(
        .RESET_VECTOR(16'h0000)
    ) dut (
        .clock_50  (clock_50),
        .reset_n   (reset_n),
        .ce        (ce),
        .load_lo_n (load_lo_n),
        .load_hi_n (load_hi_n),
        .d_lo      (d_lo),
        .d_hi      (d_hi),
        .pc        (pc),
        .tc        (tc)
    );

    initial clock_50 = 1'b0;
    always #5 clock_50 = ~clock_50;

    // Reference: low byte counts or loads; high byte gets +1 whenever the old low byte was FF
    // with ce set, unless it is loaded itself.
    always @(posedge clock_50) begin
        logic [7:0] lo;
        logic [7:0] hi;
        lo = m_pc[7:0];
        hi = m_pc[15:8];
        if (!reset_n) begin
            m_pc    <= 16'h0000;
            m_valid <= 1'b1;
        end else begin
            if (!load_lo_n)  lo = d_lo;
            else if (ce)     lo = m_pc[7:0] + 8'd1;
            if (!load_hi_n)                        hi = d_hi;
            else if (ce && m_pc[7:0] == 8'hFF)     hi = m_pc[15:8] + 8'd1;
            m_pc <= {hi, lo};
        end
    end

    always @(negedge clock_50) begin
        if (m_valid) begin
            n_checks++;
            if (pc !== m_pc || tc !== (ce && m_pc == 16'hFFFF)) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t pc=%h tc=%b expected pc=%h tc=%b",
                         $time, pc, tc, m_pc, (ce && m_pc == 16'hFFFF));
            end
        end
    end

    task automatic tick();
        @(posedge clock_50);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] exp_pc, input logic exp_tc);
        #1;
        n_checks++;
        if (pc !== exp_pc || tc !== exp_tc) begin
            n_fail++;
            $display("FAIL %s pc=%h tc=%b expected pc=%h tc=%b", name, pc, tc, exp_pc, exp_tc);
        end
        n_checks++;
        if (m_pc !== exp_pc) begin
            n_fail++;
            $display("FAIL %s_model model=%h expected %h", name, m_pc, exp_pc);
        end
    endtask

    task automatic far_load(input logic [15:0] v);
        load_lo_n = 1'b0;
        load_hi_n = 1'b0;
        d_lo      = v[7:0];
        d_hi      = v[15:8];
        tick();
        load_lo_n = 1'b1;
        load_hi_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        ce        = 1'b1;
        load_lo_n = 1'b0;
        load_hi_n = 1'b1;
        d_lo      = 8'h55;
        d_hi      = 8'h00;

        tick();
        tick();
        chk("reset", 16'h0000, 1'b0);
        reset_n   = 1'b1;
        load_lo_n = 1'b1;
        tick(); chk("count1", 16'h0001, 1'b0);
        tick(); chk("count2", 16'h0002, 1'b0);
        tick(); chk("count3", 16'h0003, 1'b0);

        far_load(16'h00FE); chk("load_00FE", 16'h00FE, 1'b0);
        tick();             chk("cnt_00FF", 16'h00FF, 1'b0);
        tick();             chk("carry_0100", 16'h0100, 1'b0);
        far_load(16'h0FFF); chk("load_0FFF", 16'h0FFF, 1'b0);
        tick();             chk("carry_1000", 16'h1000, 1'b0);

        far_load(16'hFFFF); chk("tc_FFFF", 16'hFFFF, 1'b1);
        tick();             chk("wrap_0000", 16'h0000, 1'b0);

        far_load(16'h12FF);
        load_lo_n = 1'b0; d_lo = 8'h40;
        tick(); load_lo_n = 1'b1;
        chk("near_quirk", 16'h1340, 1'b0);
        far_load(16'h1280);
        load_lo_n = 1'b0; d_lo = 8'h40;
        tick(); load_lo_n = 1'b1;
        chk("near_plain", 16'h1240, 1'b0);

        far_load(16'h3456);
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("hold", 16'h3456, 1'b0);
        end
        far_load(16'hABCD); chk("load_ce0", 16'hABCD, 1'b0);
        far_load(16'hFFFF); chk("tc_ce0", 16'hFFFF, 1'b0);
        tick();             chk("hold_FFFF", 16'hFFFF, 1'b0);
        ce = 1'b1;
        #1 chk("tc_ce1", 16'hFFFF, 1'b1);

        far_load(16'h2010);
        load_hi_n = 1'b0; d_hi = 8'h7F;
        tick(); load_hi_n = 1'b1;
        chk("hi_only", 16'h7F11, 1'b0);

        reset_n = 1'b0; load_lo_n = 1'b0; load_hi_n = 1'b0; d_lo = 8'hEE; d_hi = 8'hDD;
        tick();
        reset_n = 1'b1; load_lo_n = 1'b1; load_hi_n = 1'b1;
        chk("reset_mid_load", 16'h0000, 1'b0);

        for (int i = 0; i < 400; i++) begin
            ce        = ($urandom_range(0, 7) != 0);
            load_lo_n = ($urandom_range(0, 9) != 0);
            load_hi_n = ($urandom_range(0, 9) != 0);
            d_lo      = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            d_hi      = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            reset_n   = ($urandom_range(0, 99) != 0);
            tick();
        end
        reset_n = 1'b1; load_lo_n = 1'b1; load_hi_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
